// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank/bullet constants, state type and direction decode
package tank_pkg;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   localparam int TANK_SIZE   = 32;
   localparam int BULLET_SIZE = 8;
   localparam logic [9:0] PARK_POS = 10'd1000;

   typedef enum logic [1:0] {IDLE, FLY, EXPLODE, COOLDOWN} bullet_state_t;

   // Lowest set bit wins, same priority the sprite renderer uses.
   function automatic logic [3:0] decode_dir(input logic [3:0] raw);
      if (raw[0])      return DIR_UP;
      else if (raw[1]) return DIR_DOWN;
      else if (raw[2]) return DIR_LEFT;
      else if (raw[3]) return DIR_RIGHT;
      else             return DIR_NONE;
   endfunction

endpackage

// File: rtl/bullet_controller_if.sv
// rtl/bullet_controller_if.sv - tank-side request and renderer-side bullet signals
interface bullet_controller_if;
   logic       frame_tick;
   logic       fire;
   logic [9:0] tankx;
   logic [9:0] tanky;
   logic [3:0] TankDir;
   logic       hit;
   logic [9:0] bullet_x;
   logic [9:0] bullet_y;
   logic [3:0] bullet_dir;
   logic       bullet_active;
   logic       bullet_exploding;

   modport master (
      output frame_tick, fire, tankx, tanky, TankDir, hit,
      input  bullet_x, bullet_y, bullet_dir, bullet_active, bullet_exploding
   );

   modport slave (
      input  frame_tick, fire, tankx, tanky, TankDir, hit,
      output bullet_x, bullet_y, bullet_dir, bullet_active, bullet_exploding
   );
endinterface

// File: rtl/bullet_spawn_calc.sv
// rtl/bullet_spawn_calc.sv - spawn position of an 8x8 bullet beside a 32x32 tank
module bullet_spawn_calc
   import tank_pkg::*;
#(
   parameter int FIELD_W = 640,
   parameter int FIELD_H = 480
) (
   input  logic [9:0] tankx_i,
   input  logic [9:0] tanky_i,
   input  logic [3:0] dir_i,
   output logic [9:0] spawn_x_o,
   output logic [9:0] spawn_y_o,
   output logic       spawn_ok_o
);

   localparam logic [9:0]  CENTER = 10'((TANK_SIZE - BULLET_SIZE) / 2);
   localparam logic [9:0]  TSZ    = 10'(TANK_SIZE);
   localparam logic [9:0]  BSZ    = 10'(BULLET_SIZE);
   localparam logic [10:0] REACH  = 11'(TANK_SIZE + BULLET_SIZE);
   localparam logic [10:0] W11    = 11'(FIELD_W);
   localparam logic [10:0] H11    = 11'(FIELD_H);

   logic [10:0] tx11;
   logic [10:0] ty11;

   assign tx11 = {1'b0, tankx_i};
   assign ty11 = {1'b0, tanky_i};

   // Far-side checks use 11 bits so a tank near 1023 cannot wrap into range.
   always_comb begin
      spawn_x_o  = tankx_i;
      spawn_y_o  = tanky_i;
      spawn_ok_o = 1'b0;
      case (dir_i)
         DIR_UP: begin
            spawn_x_o  = tankx_i + CENTER;
            spawn_y_o  = tanky_i - BSZ;
            spawn_ok_o = (ty11 >= 11'(BULLET_SIZE));
         end
         DIR_DOWN: begin
            spawn_x_o  = tankx_i + CENTER;
            spawn_y_o  = tanky_i + TSZ;
            spawn_ok_o = (ty11 + REACH <= H11);
         end
         DIR_LEFT: begin
            spawn_x_o  = tankx_i - BSZ;
            spawn_y_o  = tanky_i + CENTER;
            spawn_ok_o = (tx11 >= 11'(BULLET_SIZE));
         end
         DIR_RIGHT: begin
            spawn_x_o  = tankx_i + TSZ;
            spawn_y_o  = tanky_i + CENTER;
            spawn_ok_o = (tx11 + REACH <= W11);
         end
         default: spawn_ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/bullet_controller.sv
// rtl/bullet_controller.sv - per-tank bullet launch, flight, explosion and cooldown
module bullet_controller
   import tank_pkg::*;
#(
   parameter int SPEED           = 4,
   parameter int FIELD_W         = 640,
   parameter int FIELD_H         = 480,
   parameter int EXPLODE_FRAMES  = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic                vga_clk,
   input  logic                reset_n,
   bullet_controller_if.slave  bif
);

   localparam logic [9:0]  SPD10   = 10'(SPEED);
   localparam logic [10:0] SPD11   = 11'(SPEED);
   localparam logic [10:0] BSZ11   = 11'(BULLET_SIZE);
   localparam logic [10:0] W11     = 11'(FIELD_W);
   localparam logic [10:0] H11     = 11'(FIELD_H);
   localparam logic [3:0]  EXP_CNT = 4'(EXPLODE_FRAMES);
   localparam logic [3:0]  CD_CNT  = 4'(COOLDOWN_FRAMES);

   bullet_state_t state_q;
   logic [9:0]    x_q;
   logic [9:0]    y_q;
   logic [3:0]    dir_q;
   logic          active_q;
   logic          exploding_q;
   logic [3:0]    cnt_q;
   logic          fire_q;

   logic          fire_edge;
   logic [3:0]    dir_dec;
   logic [9:0]    spawn_x;
   logic [9:0]    spawn_y;
   logic          spawn_ok;
   logic [9:0]    step_x_d;
   logic [9:0]    step_y_d;
   logic          step_oob;
   logic [10:0]   x11;
   logic [10:0]   y11;

   assign fire_edge = bif.fire & ~fire_q;
   assign dir_dec   = decode_dir(bif.TankDir);
   assign x11       = {1'b0, x_q};
   assign y11       = {1'b0, y_q};

   bullet_spawn_calc #(
      .FIELD_W (FIELD_W),
      .FIELD_H (FIELD_H)
   ) u_spawn (
      .tankx_i    (bif.tankx),
      .tanky_i    (bif.tanky),
      .dir_i      (dir_dec),
      .spawn_x_o  (spawn_x),
      .spawn_y_o  (spawn_y),
      .spawn_ok_o (spawn_ok)
   );

   // Next step uses the direction latched at spawn, not the live TankDir.
   always_comb begin
      step_x_d = x_q;
      step_y_d = y_q;
      step_oob = 1'b1;
      case (dir_q)
         DIR_UP: begin
            step_y_d = y_q - SPD10;
            step_oob = (y11 < SPD11);
         end
         DIR_DOWN: begin
            step_y_d = y_q + SPD10;
            step_oob = (y11 + SPD11 + BSZ11 > H11);
         end
         DIR_LEFT: begin
            step_x_d = x_q - SPD10;
            step_oob = (x11 < SPD11);
         end
         DIR_RIGHT: begin
            step_x_d = x_q + SPD10;
            step_oob = (x11 + SPD11 + BSZ11 > W11);
         end
         default: step_oob = 1'b1;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         x_q         <= PARK_POS;
         y_q         <= PARK_POS;
         dir_q       <= DIR_NONE;
         active_q    <= 1'b0;
         exploding_q <= 1'b0;
         cnt_q       <= 4'd0;
         fire_q      <= 1'b1;
      end else begin
         fire_q <= bif.fire;
         case (state_q)
            IDLE: begin
               if (fire_edge && (dir_dec != DIR_NONE)) begin
                  if (spawn_ok) begin
                     state_q  <= FLY;
                     x_q      <= spawn_x;
                     y_q      <= spawn_y;
                     dir_q    <= dir_dec;
                     active_q <= 1'b1;
                  end else begin
                     state_q <= COOLDOWN;
                     cnt_q   <= CD_CNT;
                  end
               end
            end
            FLY: begin
               if (bif.hit || (bif.frame_tick && step_oob)) begin
                  state_q     <= EXPLODE;
                  dir_q       <= DIR_NONE;
                  active_q    <= 1'b0;
                  exploding_q <= 1'b1;
                  cnt_q       <= EXP_CNT;
               end else if (bif.frame_tick) begin
                  x_q <= step_x_d;
                  y_q <= step_y_d;
               end
            end
            EXPLODE: begin
               if (bif.frame_tick) begin
                  if (cnt_q <= 4'd1) begin
                     state_q     <= COOLDOWN;
                     x_q         <= PARK_POS;
                     y_q         <= PARK_POS;
                     exploding_q <= 1'b0;
                     cnt_q       <= CD_CNT;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            COOLDOWN: begin
               if (bif.frame_tick) begin
                  if (cnt_q <= 4'd1) begin
                     state_q <= IDLE;
                     cnt_q   <= 4'd0;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bif.bullet_x         = x_q;
   assign bif.bullet_y         = y_q;
   assign bif.bullet_dir       = dir_q;
   assign bif.bullet_active    = active_q;
   assign bif.bullet_exploding = exploding_q;

endmodule

// File: tb/tb_bullet_controller.sv
// tb/tb_bullet_controller.sv - scoreboard bench for bullet_controller
module tb_bullet_controller;
   import tank_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bullet_controller_if bif();

   bullet_controller dut (
      .vga_clk (clk),
      .reset_n (rst_n),
      .bif     (bif)
   );

   typedef struct {
      string       name;
      logic [34:0] v;
   } exp_t;

   exp_t        sb[$];
   logic [34:0] obsq[$];
   int          passed = 0;
   int          total  = 0;

   localparam logic [34:0] PARKED = {10'd1000, 10'd1000, 4'd0, 1'b0, 1'b0};

   function automatic logic [34:0] pk(int x, int y, logic [3:0] d, logic a, logic e);
      return {10'(x), 10'(y), d, a, e};
   endfunction

   function automatic logic [34:0] obs();
      return {bif.bullet_x, bif.bullet_y, bif.bullet_dir, bif.bullet_active, bif.bullet_exploding};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic step_exp(string n, logic [34:0] v);
      sb.push_back('{n, v});
      cyc();
      obsq.push_back(obs());
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) begin
         bif.frame_tick = 1'b1;
         cyc();
         bif.frame_tick = 1'b0;
         cyc();
      end
   endtask

   task automatic end_shot();
      bif.hit = 1'b1;
      cyc();
      bif.hit = 1'b0;
      ticks(12);
   endtask

   task automatic test_reset();
      exp_t e;
      logic [34:0] o;
      rst_n = 1'b0;
      bif.fire = 1'b1;
      step_exp("reset_parked", PARKED);
      rst_n = 1'b1;
      step_exp("reset_fire_held", PARKED);
      step_exp("reset_fire_held2", PARKED);
      bif.fire = 1'b0;
      cyc();
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   task automatic test_fly_up();
      exp_t e;
      logic [34:0] o;
      bif.tankx = 10'd100; bif.tanky = 10'd200; bif.TankDir = 4'b0001;
      bif.fire = 1'b1;
      step_exp("spawn_up", pk(112, 192, DIR_UP, 1, 0));
      bif.fire = 1'b0;
      bif.TankDir = 4'b1000;
      for (int i = 1; i <= 3; i++) begin
         bif.frame_tick = 1'b1;
         step_exp("fly_up_tick", pk(112, 192 - 4 * i, DIR_UP, 1, 0));
         bif.frame_tick = 1'b0;
         step_exp("fly_up_hold", pk(112, 192 - 4 * i, DIR_UP, 1, 0));
      end
      bif.hit = 1'b1;
      step_exp("hit_explode", pk(112, 180, 0, 0, 1));
      bif.hit = 1'b0;
      ticks(3);
      step_exp("explode_hold", pk(112, 180, 0, 0, 1));
      bif.frame_tick = 1'b1;
      step_exp("explode_done", PARKED);
      bif.frame_tick = 1'b0;
      ticks(8);
      bif.TankDir = 4'b0001;
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   task automatic test_right_edge();
      exp_t e;
      logic [34:0] o;
      bif.tankx = 10'd600; bif.tanky = 10'd100; bif.TankDir = 4'b1000;
      bif.fire = 1'b1;
      step_exp("spawn_right", pk(632, 112, DIR_RIGHT, 1, 0));
      bif.fire = 1'b0;
      bif.frame_tick = 1'b1;
      step_exp("right_edge_explode", pk(632, 112, 0, 0, 1));
      bif.frame_tick = 1'b0;
      ticks(3);
      bif.frame_tick = 1'b1;
      step_exp("right_parked", PARKED);
      bif.frame_tick = 1'b0;
      bif.fire = 1'b1;
      step_exp("cooldown_fire_early", PARKED);
      bif.fire = 1'b0;
      cyc();
      ticks(7);
      bif.fire = 1'b1;
      step_exp("cooldown_fire_late", PARKED);
      bif.fire = 1'b0;
      cyc();
      ticks(1);
      bif.fire = 1'b1;
      step_exp("after_cooldown_fire", pk(632, 112, DIR_RIGHT, 1, 0));
      bif.fire = 1'b0;
      end_shot();
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   task automatic test_hit_priority();
      exp_t e;
      logic [34:0] o;
      bif.tankx = 10'd100; bif.tanky = 10'd200; bif.TankDir = 4'b0001;
      bif.fire = 1'b1;
      step_exp("hit_spawn", pk(112, 192, DIR_UP, 1, 0));
      bif.fire = 1'b0;
      bif.hit = 1'b1; bif.frame_tick = 1'b1;
      step_exp("hit_beats_tick", pk(112, 192, 0, 0, 1));
      bif.hit = 1'b0; bif.frame_tick = 1'b0;
      ticks(12);
      step_exp("hit_back_idle", PARKED);
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   task automatic test_fire_held();
      exp_t e;
      logic [34:0] o;
      int spawns = 0;
      int expl_y = -1;
      logic prev_active = 1'b0;
      bif.tankx = 10'd100; bif.tanky = 10'd200; bif.TankDir = 4'b0001;
      bif.fire = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bif.frame_tick = (i % 2 == 0);
         cyc();
         if (bif.bullet_active && !prev_active) spawns++;
         prev_active = bif.bullet_active;
         if (bif.bullet_exploding && expl_y < 0) expl_y = int'(bif.bullet_y);
      end
      bif.frame_tick = 1'b0;
      total++;
      if (spawns !== 1) $display("FAIL held_spawn_count: got %0d want 1", spawns);
      else passed++;
      total++;
      if (expl_y !== 0) $display("FAIL top_edge_explode_y: got %0d want 0", expl_y);
      else passed++;
      step_exp("held_parked", PARKED);
      bif.fire = 1'b0;
      cyc();
      bif.fire = 1'b1;
      step_exp("held_refire", pk(112, 192, DIR_UP, 1, 0));
      bif.fire = 1'b0;
      end_shot();
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   task automatic test_invalid_spawn();
      exp_t e;
      logic [34:0] o;
      bif.tankx = 10'd100; bif.tanky = 10'd4; bif.TankDir = 4'b0001;
      bif.fire = 1'b1;
      step_exp("bad_spawn_parked", PARKED);
      bif.fire = 1'b0;
      step_exp("bad_spawn_parked2", PARKED);
      bif.tanky = 10'd200;
      ticks(7);
      bif.fire = 1'b1;
      step_exp("bad_spawn_cooldown", PARKED);
      bif.fire = 1'b0;
      cyc();
      ticks(1);
      bif.fire = 1'b1;
      step_exp("bad_spawn_recover", pk(112, 192, DIR_UP, 1, 0));
      bif.fire = 1'b0;
      end_shot();
      bif.TankDir = 4'b0000;
      bif.fire = 1'b1;
      step_exp("nodir_parked", PARKED);
      bif.fire = 1'b0;
      cyc();
      bif.TankDir = 4'b0110;
      bif.fire = 1'b1;
      step_exp("nodir_still_idle", pk(112, 232, DIR_DOWN, 1, 0));
      bif.fire = 1'b0;
      end_shot();
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   task automatic test_reset_fly();
      exp_t e;
      logic [34:0] o;
      bif.tankx = 10'd100; bif.tanky = 10'd200; bif.TankDir = 4'b0001;
      bif.fire = 1'b1;
      step_exp("rf_spawn", pk(112, 192, DIR_UP, 1, 0));
      bif.frame_tick = 1'b1;
      step_exp("rf_move", pk(112, 188, DIR_UP, 1, 0));
      bif.frame_tick = 1'b0;
      rst_n = 1'b0;
      step_exp("rf_reset", PARKED);
      rst_n = 1'b1;
      step_exp("rf_held", PARKED);
      step_exp("rf_held2", PARKED);
      bif.fire = 1'b0;
      cyc();
      bif.fire = 1'b1;
      step_exp("rf_refire", pk(112, 192, DIR_UP, 1, 0));
      bif.fire = 1'b0;
      end_shot();
      while (sb.size() > 0) begin
         e = sb.pop_front(); o = obsq.pop_front(); total++;
         if (o !== e.v) $display("FAIL %s: got %h want %h", e.name, o, e.v);
         else passed++;
      end
   endtask

   initial begin
      bif.frame_tick = 1'b0;
      bif.fire       = 1'b0;
      bif.hit        = 1'b0;
      bif.tankx      = 10'd100;
      bif.tanky      = 10'd200;
      bif.TankDir    = 4'b0001;
      test_reset();
      test_fly_up();
      test_right_edge();
      test_hit_priority();
      test_fire_held();
      test_invalid_spawn();
      test_reset_fly();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
- Upstream of the tank/bullet sprite renderer; one instance per tank.
- Converts a fire request plus the tank's position and direction into a moving 8x8 bullet.
- Advances the bullet once per video frame and ends it at the playfield edge or on an external hit.
- Drives bullet_x, bullet_y and bullet_dir directly into the renderer. bullet_dir = 0 during the explosion hold makes the renderer draw its default white flash.

Parameters:
SPEED, 4, pixels moved per frame_tick
FIELD_W, 640, playfield width in pixels (exclusive bound)
FIELD_H, 480, playfield height in pixels (exclusive bound)
EXPLODE_FRAMES, 4, frame_ticks the bullet is held in place after termination
COOLDOWN_FRAMES, 8, frame_ticks after explosion before the next shot is accepted

Ports:
vga_clk  in  1  single clock; all logic on its rising edge
reset_n  in  1  synchronous reset, active-low
frame_tick  in  1  one-cycle pulse per frame, synchronous to vga_clk
fire  in  1  fire request level, synchronous to vga_clk
tankx  in  10  tank top-left X
tanky  in  10  tank top-left Y
TankDir  in  4  one-hot tank direction: 1 = Up, 2 = Down, 4 = Left, 8 = Right
hit  in  1  collision from map/enemy logic, valid only while bullet_active
bullet_x  out  10  bullet top-left X
bullet_y  out  10  bullet top-left Y
bullet_dir  out  4  one-hot direction while flying; 0 while exploding or parked
bullet_active  out  1  high in FLY only
bullet_exploding  out  1  high in EXPLODE only

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - state = IDLE; bullet_x = bullet_y = PARK_POS (1000); bullet_dir = 0; bullet_active = 0; bullet_exploding = 0; frame counter = 0.
  - fire_q = 1, so a fire held through reset never launches a shot.
  - Reset mid-flight aborts immediately with the same values.
- Fire detection: fire_q registers fire every cycle; fire_edge = fire & ~fire_q.
  - An edge seen outside IDLE is discarded, not queued.
- TankDir decoding: priority bit0 > bit1 > bit2 > bit3, matching the renderer. TankDir = 0 with fire_edge is ignored.
- All arithmetic is 10-bit unsigned. Bound checks are done in 11 bits so values never wrap.
- Spawn position (tank is 32x32, bullet is 8x8):
  - Up: (tankx+12, tanky-8); valid if tanky >= 8.
  - Down: (tankx+12, tanky+32); valid if tanky+40 <= FIELD_H.
  - Left: (tankx-8, tanky+12); valid if tankx >= 8.
  - Right: (tankx+32, tanky+12); valid if tankx+40 <= FIELD_W.
- States:
  - IDLE: outputs parked.
    - fire_edge with valid decoded dir and valid spawn: next cycle FLY, position = spawn, bullet_dir = latched dir. Latency is 1 cycle.
    - fire_edge with invalid spawn: go to COOLDOWN, counter = COOLDOWN_FRAMES; bullet_active never asserts.
  - FLY: direction is latched at spawn; later TankDir changes are ignored.
    - hit = 1: go to EXPLODE; position unchanged. hit wins over a simultaneous frame_tick.
    - frame_tick with the next step in bounds: move SPEED pixels in the latched direction.
    - frame_tick with the next step out of bounds: go to EXPLODE at the current position.
    - Out of bounds means: Up y < SPEED; Down y+SPEED+8 > FIELD_H; Left x < SPEED; Right x+SPEED+8 > FIELD_W.
  - EXPLODE: position held; bullet_dir = 0; bullet_exploding = 1; counter loaded with EXPLODE_FRAMES.
    - Each frame_tick decrements the counter.
    - The tick that reaches 0 moves to COOLDOWN with outputs parked and counter = COOLDOWN_FRAMES.
  - COOLDOWN: outputs parked; same countdown, then IDLE.
    - IDLE accepts fire from the first cycle after entry, but needs a fresh edge.
- Counter: 4 bits. Parameters above 15 are illegal.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package tank_pkg holds:
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT (4-bit one-hot);
  - TANK_SIZE = 32, BULLET_SIZE = 8, PARK_POS = 10'd1000;
  - bullet_state_t enum {IDLE, FLY, EXPLODE, COOLDOWN}.
- Sub-module bullet_spawn_calc (combinational): inputs tankx, tanky, decoded dir; outputs spawn_x, spawn_y, spawn_ok.

Test Plan:
- tankx = 100, tanky = 200, TankDir = 0001, 1-cycle fire:
  - next cycle bullet_x = 112, bullet_y = 192, dir = 0001, active = 1;
  - after 3 frame_ticks bullet_y = 180.
- tankx = 600, tanky = 100, TankDir = 1000, fire:
  - spawn (632, 112); first frame_tick gives exploding = 1, dir = 0, x = 632;
  - 4 ticks later parked at 1000; fire during cooldown ignored; IDLE after 8 more ticks.
- In FLY at (112, 192) going Up, assert hit and frame_tick in the same cycle -> EXPLODE with y = 192, unmoved.
- fire held high for 200 frames -> exactly one shot, and no re-fire after cooldown until fire drops and rises again.
- tanky = 4, TankDir = 0001, fire -> bullet_active never high; COOLDOWN entered. Separately, TankDir = 0, fire -> stays IDLE.
- reset_n low for 1 cycle during FLY with fire held -> next cycle parked, IDLE, dir = 0; no shot until fire is released and re-pressed.
